// File: rtl/audio_mixer_dac.sv
// Mixes PSG, beeper/PIT and covox into 16-bit stereo PCM with a mute ramp,
// and drives first-order sigma-delta 1-bit outputs per channel.
module audio_mixer_dac #(
  parameter int CLK_HZ    = 96_000_000,
  parameter int SAMPLE_HZ = 48_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  psg_ch_a,
  input  logic [7:0]  psg_ch_b,
  input  logic [7:0]  psg_ch_c,
  input  logic [5:0]  psg_active,
  input  logic [2:0]  legacy,
  input  logic [7:0]  covox,
  input  logic        mute,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_strobe,
  output logic        audio_l,
  output logic        audio_r
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic [10:0]   r_mix_l;
  logic [10:0]   r_mix_r;
  logic [8:0]    r_gain;
  logic          r_stb;
  logic [15:0]   r_sample_l;
  logic [15:0]   r_sample_r;
  logic [16:0]   r_acc_l;
  logic [16:0]   r_acc_r;

  logic          w_tick;
  logic [10:0]   w_mix_l;
  logic [10:0]   w_mix_r;
  logic [19:0]   w_prod_l;
  logic [19:0]   w_prod_r;

  assign w_tick = (r_div == DIV_LAST);

  // Worst case is 1534 on either path, so 11 bits never overflow
  always_comb begin
    w_mix_l = {legacy, 8'b0} + {2'b0, covox, 1'b0};
    w_mix_r = w_mix_l;
    if (psg_active != 6'd0) begin
      w_mix_l = {2'b0, psg_ch_a, 1'b0} + {3'b0, psg_ch_b}
              + {1'b0, legacy, 7'b0};
      w_mix_r = {2'b0, psg_ch_c, 1'b0} + {3'b0, psg_ch_b}
              + {1'b0, legacy, 7'b0};
    end
  end

  assign w_prod_l = 20'(r_mix_l) * 20'(r_gain);
  assign w_prod_r = 20'(r_mix_r) * 20'(r_gain);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_div      <= '0;
      r_mix_l    <= '0;
      r_mix_r    <= '0;
      r_gain     <= '0;
      r_stb      <= 1'b0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      r_stb <= w_tick;
      if (w_tick) begin
        r_mix_l <= w_mix_l;
        r_mix_r <= w_mix_r;
        if (mute) begin
          if (r_gain != 9'd0) r_gain <= r_gain - 9'd1;
        end else begin
          if (r_gain != 9'd256) r_gain <= r_gain + 9'd1;
        end
      end
      // Stage 2 sees the gain already stepped by the preceding tick
      if (r_stb) begin
        r_sample_l <= 16'(((w_prod_l >> 8) & 20'h7FF) << 5);
        r_sample_r <= 16'(((w_prod_r >> 8) & 20'h7FF) << 5);
      end
      r_acc_l <= {1'b0, r_acc_l[15:0]} + {1'b0, r_sample_l};
      r_acc_r <= {1'b0, r_acc_r[15:0]} + {1'b0, r_sample_r};
    end
  end

  assign sample_l      = r_sample_l;
  assign sample_r      = r_sample_r;
  assign sample_strobe = r_stb;
  assign audio_l       = r_acc_l[16];
  assign audio_r       = r_acc_r[16];

endmodule

// File: tb/tb_audio_mixer_dac.sv
// Directed bench for audio_mixer_dac: divider, mix paths, gain ramp,
// sigma-delta density and mid-operation reset.
module tb_audio_mixer_dac;

  localparam int DIV = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  psg_ch_a = '0;
  logic [7:0]  psg_ch_b = '0;
  logic [7:0]  psg_ch_c = '0;
  logic [5:0]  psg_active = '0;
  logic [2:0]  legacy = '0;
  logic [7:0]  covox = '0;
  logic        mute = 1'b0;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_strobe;
  logic        audio_l;
  logic        audio_r;

  int n_cmp = 0;
  int n_fail = 0;

  audio_mixer_dac #(
    .CLK_HZ(384_000),
    .SAMPLE_HZ(48_000)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .psg_ch_a(psg_ch_a),
    .psg_ch_b(psg_ch_b),
    .psg_ch_c(psg_ch_c),
    .psg_active(psg_active),
    .legacy(legacy),
    .covox(covox),
    .mute(mute),
    .sample_l(sample_l),
    .sample_r(sample_r),
    .sample_strobe(sample_strobe),
    .audio_l(audio_l),
    .audio_r(audio_r)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic set_in(input logic [5:0] act, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [2:0] leg, input logic [7:0] cov);
    psg_active = act;
    psg_ch_a = a;
    psg_ch_b = b;
    psg_ch_c = c;
    legacy = leg;
    covox = cov;
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      @(negedge clk_sys);
      if (sample_strobe) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL strobe_timeout: none within %0d cycles", 3 * DIV);
    end
  endtask

  task automatic get_sample(output logic [15:0] l, output logic [15:0] r);
    wait_strobe();
    @(negedge clk_sys);
    l = sample_l;
    r = sample_r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_cmp++;
    if ({sample_l, sample_r} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_samples: got %h/%h want 0", sample_l, sample_r);
    end
    n_cmp++;
    if ({sample_strobe, audio_l, audio_r} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_bits: got %b want 000",
               {sample_strobe, audio_l, audio_r});
    end
    reset = 1'b0;
  endtask

  task automatic test_divider();
    logic exp;
    apply_reset();
    for (int k = 1; k <= 3 * DIV + 2; k++) begin
      @(negedge clk_sys);
      exp = (k % DIV == 0);
      n_cmp++;
      if (sample_strobe !== exp) begin
        n_fail++;
        $display("FAIL divider cyc %0d: got %b want %b", k, sample_strobe, exp);
      end
    end
  endtask

  task automatic test_fade_in();
    logic [15:0] l, r;
    set_in(6'd0, 8'd0, 8'd0, 8'd0, 3'd4, 8'd0);
    apply_reset();
    for (int n = 1; n <= 257; n++) begin
      get_sample(l, r);
      if (n == 1 || n == 2 || n == 256 || n == 257) begin
        logic [15:0] exp;
        exp = (n == 1) ? 16'd128 : (n == 2) ? 16'd256 : 16'd32768;
        n_cmp++;
        if (l !== exp || r !== exp) begin
          n_fail++;
          $display("FAIL fade_in n=%0d: got %0d/%0d want %0d", n, l, r, exp);
        end
      end
    end
  endtask

  task automatic test_psg();
    logic [15:0] l, r;
    set_in(6'd1, 8'd100, 8'd50, 8'd20, 3'd2, 8'd0);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd16192 || r !== 16'd11072) begin
      n_fail++;
      $display("FAIL psg_basic: got %0d/%0d want 16192/11072", l, r);
    end
    set_in(6'h20, 8'd255, 8'd255, 8'd0, 3'd4, 8'd99);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd40864 || r !== 16'd24544) begin
      n_fail++;
      $display("FAIL psg_high: got %0d/%0d want 40864/24544", l, r);
    end
  endtask

  task automatic test_covox();
    logic [15:0] l, r;
    set_in(6'd0, 8'd77, 8'd88, 8'd99, 3'd1, 8'd128);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd16384 || r !== 16'd16384) begin
      n_fail++;
      $display("FAIL covox_mid: got %0d/%0d want 16384", l, r);
    end
    set_in(6'd0, 8'd0, 8'd0, 8'd0, 3'd4, 8'd255);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd49088 || r !== 16'd49088) begin
      n_fail++;
      $display("FAIL covox_max: got %0d/%0d want 49088", l, r);
    end
  endtask

  task automatic test_sigma_delta();
    logic [15:0] l, r;
    logic [7:0]  bits;
    int ones_l, ones_r;
    set_in(6'd0, 8'd0, 8'd0, 8'd0, 3'd1, 8'd128);
    get_sample(l, r);
    ones_l = 0;
    ones_r = 0;
    bits = '0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk_sys);
      if (i < 8) bits[i] = audio_l;
      ones_l += int'(audio_l);
      ones_r += int'(audio_r);
    end
    n_cmp++;
    if (ones_l != 1024 || ones_r != 1024) begin
      n_fail++;
      $display("FAIL sd_density: got %0d/%0d want 1024", ones_l, ones_r);
    end
    n_cmp++;
    if (bits[3:0] !== bits[7:4] || $countones(bits[3:0]) != 1) begin
      n_fail++;
      $display("FAIL sd_period: got %b want period-4 single one", bits);
    end
    set_in(6'd0, 8'd0, 8'd0, 8'd0, 3'd0, 8'd0);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd0 || r !== 16'd0) begin
      n_fail++;
      $display("FAIL sd_zero_sample: got %0d/%0d want 0", l, r);
    end
    @(negedge clk_sys);
    ones_l = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_sys);
      ones_l += int'(audio_l) + int'(audio_r);
    end
    n_cmp++;
    if (ones_l != 0) begin
      n_fail++;
      $display("FAIL sd_zero: got %0d ones want 0", ones_l);
    end
  endtask

  task automatic test_mute_ramp();
    logic [15:0] l, r;
    set_in(6'd0, 8'd0, 8'd0, 8'd0, 3'd4, 8'd0);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd32768) begin
      n_fail++;
      $display("FAIL mute_start: got %0d want 32768", l);
    end
    mute = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      get_sample(l, r);
      if (k == 1 || k == 128 || k == 256 || k == 257) begin
        logic [15:0] exp;
        exp = (k == 1) ? 16'd32640 : (k == 128) ? 16'd16384 : 16'd0;
        n_cmp++;
        if (l !== exp || r !== exp) begin
          n_fail++;
          $display("FAIL mute_ramp k=%0d: got %0d/%0d want %0d", k, l, r, exp);
        end
      end
    end
    mute = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      get_sample(l, r);
      if (k == 1 || k == 102) begin
        logic [15:0] exp;
        exp = (k == 1) ? 16'd128 : 16'd13056;
        n_cmp++;
        if (l !== exp) begin
          n_fail++;
          $display("FAIL unmute_ramp k=%0d: got %0d want %0d", k, l, exp);
        end
      end
    end
    mute = 1'b1;
    get_sample(l, r);
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd12800) begin
      n_fail++;
      $display("FAIL mute_at_100: got %0d want 12800", l);
    end
    mute = 1'b0;
    get_sample(l, r);
    n_cmp++;
    if (l !== 16'd12928) begin
      n_fail++;
      $display("FAIL reverse_101: got %0d want 12928", l);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] l, r;
    logic        exp;
    for (int k = 0; k < 99; k++) get_sample(l, r);
    n_cmp++;
    if (l !== 16'd25600) begin
      n_fail++;
      $display("FAIL gain_200: got %0d want 25600", l);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if ({sample_l, sample_r, sample_strobe, audio_l, audio_r} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got %h/%h %b%b%b want 0", sample_l,
               sample_r, sample_strobe, audio_l, audio_r);
    end
    reset = 1'b0;
    for (int k = 1; k <= DIV; k++) begin
      @(negedge clk_sys);
      exp = (k == DIV);
      n_cmp++;
      if (sample_strobe !== exp) begin
        n_fail++;
        $display("FAIL mid_reset_strobe cyc %0d: got %b want %b", k,
                 sample_strobe, exp);
      end
    end
    @(negedge clk_sys);
    n_cmp++;
    if (sample_l !== 16'd128) begin
      n_fail++;
      $display("FAIL gain_restart: got %0d want 128", sample_l);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_fade_in();
    test_psg();
    test_covox();
    test_sigma_delta();
    test_mute_ramp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mixer_dac.md
# audio_mixer_dac

Mixes the PSG channels, the legacy beeper/PIT sum and the covox byte into 16-bit stereo PCM at a fixed sample rate, applies a click-free mute ramp, and drives first-order sigma-delta 1-bit outputs. It sits between the sound sources (ym2149, k580vi53, covox latch) and the audio outputs. Its PCM samples feed the i2s transmitter, and its 1-bit streams drive AUDIO_L/AUDIO_R.

## Interface
- CLK_HZ, 96_000_000, clk_sys frequency.
- SAMPLE_HZ, 48_000, PCM sample rate. DIV = CLK_HZ/SAMPLE_HZ must be an integer ≥ 4.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- psg_ch_a, psg_ch_b, psg_ch_c  in  8 each  unsigned PSG channel levels.
- psg_active  in  6  nonzero selects the PSG mix path.
- legacy  in  3  beeper+PIT count, 0..4.
- covox  in  8  unsigned covox level.
- mute  in  1  1 = ramp the output to silence.
- sample_l, sample_r  out  16  unsigned PCM.
- sample_strobe  out  1  one-cycle pulse when sample_l/r update.
- audio_l, audio_r  out  1  sigma-delta bitstreams.

## Operation
- Divider:
  - div counts 0..DIV-1 and wraps.
  - tick is asserted combinationally when div == DIV-1.
- Stage 1 (registered on tick), per channel, 11-bit unsigned:
  - psg_active != 0: mix_l = 2·a + b + 128·legacy; mix_r = 2·c + b + 128·legacy.
  - psg_active == 0: mix_l = mix_r = 256·legacy + 2·covox.
  - Maximum value is 1534, so no saturation is needed.
  - Inputs are sampled only on tick; changes between ticks are ignored.
- Gain (9-bit, range 0..256):
  - Updates on tick after stage 1 captures.
  - mute = 0: gain increments by 1 per tick, saturating at 256.
  - mute = 1: gain decrements by 1 per tick, saturating at 0.
  - Stage 2 uses the gain value registered at the time stage 2 executes.
- Stage 2 (one cycle after tick):
  - scaled = (mix × gain) >> 8, with a 20-bit product and the low 11 bits kept.
  - sample = {scaled[10:0], 5'b0}.
  - sample_l/r register in the same cycle as sample_strobe = 1.
- Sigma-delta, every clk_sys, per channel:
  - acc[16:0] ← {1'b0, acc[15:0]} + sample.
  - audio = acc[16], registered.
  - Long-run ones density = sample/65536.
  - sample = 0 gives constant 0.

## Timing
- Reset values:
  - div, mix, sample_l/r, acc: 0.
  - sample_strobe, audio_l/r: 0.
  - gain: 0, so every start fades in over 256 ticks when mute = 0.
- The first tick occurs DIV cycles after reset deasserts (div reaches DIV-1).
- Pipeline:
  - Cycle T: tick, inputs captured into mix.
  - Cycle T+1: sample computed, sample_strobe high.
  - Cycle T+2: first accumulator update using the new sample.
  - Input-to-PCM latency is 2 cycles.
- sample_strobe period is exactly DIV cycles; pulse width is 1 cycle.
- Gain ramp: a full fade from 256 to 0 (or 0 to 256) takes 256 ticks, 5.33 ms at 48 kHz.
- Mute toggled mid-ramp reverses direction from the current gain on the next tick; there is no jump.
- Reset mid-ramp or mid-sample: every register returns to its reset value on the next edge. No strobe is emitted in the reset cycle or for DIV-1 cycles after.
- Gain at 256 with mute = 0, or at 0 with mute = 1, holds steady (saturation boundary).

## Test plan
- Divider: DIV = 2000, reset released at cycle 0 → sample_strobe pulses at cycles 2000, 4000, 6000, each 1 cycle wide.
- PSG path, gain at 256: psg_active = 1, a = 100, b = 50, c = 20, legacy = 2 → sample_l = 506<<5 = 16192, sample_r = 346<<5 = 11072.
- Covox path: psg_active = 0, legacy = 1, covox = 128 → sample_l = sample_r = 16384. Then legacy = 4, covox = 255 → 1534<<5 = 49088.
- Mute ramp:
  - Start at gain 256 with mix 1024; assert mute → the 128th sample after assertion = (1024·128>>8)<<5 = 16384.
  - Silence (0) after 256 ticks.
  - Deassert mute at gain 100 → gain 101 on the next tick.
- Sigma-delta: sample held at 16384 → audio_l emits exactly 1024 ones in any aligned 4096-cycle window, pattern period 4. sample = 0 → always 0.
- Reset mid-operation: assert reset for 1 cycle at gain 200 → all outputs 0. Gain restarts from 0, and the next strobe arrives DIV cycles after release.
